multicycle_control_unit: RTL and testbench

- Parametrised successor of the single-cycle control decoder for the tiny CPU.
- Owns the instruction register and a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine.
- Handshakes with instruction and data memories that have variable latency. Evaluates branch conditions from the flag register.
- Drives PC, register-file, ALU, flag and data-memory enables, each only in the state where it applies.

---
 rtl/cu_pkg.sv | 59 +++++
 rtl/multicycle_control_unit_if.sv | 37 +++
 rtl/cu_opcode_decoder.sv | 30 +++
 rtl/multicycle_control_unit.sv | 154 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// instruction classes and the registered control payload.
package cu_pkg;

  localparam int unsigned ALU_OP_WIDTH = 4;
  localparam int unsigned STATE_WIDTH  = 3;
  localparam int unsigned WB_SRC_WIDTH = 2;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_L    = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BRZ  = 4'hA;
  localparam logic [3:0] OP_BRNZ = 4'hB;
  localparam logic [3:0] OP_BRNS = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_CMP  = 4'hF;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC1 = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_ALUI   = 3'd1,
    CLS_LI     = 3'd2,
    CLS_CMP    = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_LOAD   = 3'd5,
    CLS_STORE  = 3'd6
  } instr_class_e;

  typedef struct packed {
    logic                    dmem_req;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic [WB_SRC_WIDTH-1:0] reg_write_src;
    logic [ALU_OP_WIDTH-1:0] alu_operation;
    logic                    alu_src;
    logic                    flag_write;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory handshakes, flag inputs and datapath control strobes of the control unit.
interface multicycle_control_unit_if #(
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned PC_WIDTH    = 16
);
  logic                              imem_req;
  logic                              imem_ready;
  logic [INSTR_WIDTH-1:0]            imem_rdata;
  logic                              dmem_req;
  logic                              dmem_ready;
  logic                              zero_flag;
  logic                              sign_flag;
  logic                              pc_write;
  logic                              pc_src;
  logic [INSTR_WIDTH-1:0]            instr;
  logic                              reg_write;
  logic [cu_pkg::WB_SRC_WIDTH-1:0]   reg_write_src;
  logic                              mem_read;
  logic                              mem_write;
  logic [cu_pkg::ALU_OP_WIDTH-1:0]   alu_operation;
  logic                              alu_src;
  logic                              flag_write;
  logic [PC_WIDTH-1:0]               branch_offset;
  logic [cu_pkg::STATE_WIDTH-1:0]    state;

  modport master (
    output imem_req, dmem_req, pc_write, pc_src, instr, reg_write, reg_write_src,
           mem_read, mem_write, alu_operation, alu_src, flag_write, branch_offset, state,
    input  imem_ready, imem_rdata, dmem_ready, zero_flag, sign_flag
  );

  modport slave (
    input  imem_req, dmem_req, pc_write, pc_src, instr, reg_write, reg_write_src,
           mem_read, mem_write, alu_operation, alu_src, flag_write, branch_offset, state,
    output imem_ready, imem_rdata, dmem_ready, zero_flag, sign_flag
  );
endinterface

// File: rtl/cu_opcode_decoder.sv
// Maps an opcode to its instruction class and the ALU operation it needs.
module cu_opcode_decoder
  import cu_pkg::*;
(
  input  logic [3:0]              opcode,
  output instr_class_e            iclass_c,
  output logic [ALU_OP_WIDTH-1:0] alu_op_c
);

  always_comb begin
    iclass_c = CLS_BRANCH;
    alu_op_c = OP_ADD;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        iclass_c = CLS_ALU;
        alu_op_c = opcode;
      end
      OP_ADDI: iclass_c = CLS_ALUI;
      OP_LI:   iclass_c = CLS_LI;
      OP_CMP: begin
        iclass_c = CLS_CMP;
        alu_op_c = OP_SUB;
      end
      OP_L:    iclass_c = CLS_LOAD;
      OP_ST:   iclass_c = CLS_STORE;
      default: iclass_c = CLS_BRANCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: IR plus FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer.
// Define CU_PERF_CNT_EN to add the retired-instruction and cycle counters.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH  = 16,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned OFFSET_WIDTH = 12,
  parameter int unsigned PC_WIDTH     = 16
`ifdef CU_PERF_CNT_EN
  , parameter int unsigned CNT_WIDTH  = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_unit_if.master bus
`ifdef CU_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] retired_cnt
  , output logic [CNT_WIDTH-1:0] cycle_cnt
`endif
);

  state_e                  state_q, state_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic [3:0]              opcode;
  instr_class_e            iclass;
  logic [ALU_OP_WIDTH-1:0] dec_alu_op;
  logic                    taken;
  logic                    branch_taken;

  assign opcode = 4'(ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH]);

  cu_opcode_decoder u_opcode_decoder (
    .opcode   (opcode),
    .iclass_c (iclass),
    .alu_op_c (dec_alu_op)
  );

  // Flags are read live so a CMP retired earlier is always visible here.
  assign taken = (opcode == OP_JMP)
               | ((opcode == OP_BRZ)  &  bus.zero_flag)
               | ((opcode == OP_BRNZ) & ~bus.zero_flag)
               | ((opcode == OP_BRNS) &  bus.sign_flag);
  assign branch_taken = (state_q == ST_EXECUTE) & (iclass == CLS_BRANCH) & taken;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ctrl_d  = '0;
    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE:    state_d = (iclass == CLS_LOAD || iclass == CLS_STORE) ? ST_MEM : ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_FETCH;
      ST_MEM: begin
        if (bus.dmem_ready) state_d = (iclass == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase

    // Registered strobes are decoded from the state being entered.
    case (state_d)
      ST_EXECUTE: begin
        case (iclass)
          CLS_ALU, CLS_ALUI, CLS_LI: begin
            ctrl_d.alu_operation = dec_alu_op;
            ctrl_d.alu_src       = (iclass != CLS_ALU);
            ctrl_d.reg_write     = 1'b1;
            ctrl_d.flag_write    = (iclass != CLS_LI);
          end
          CLS_CMP: begin
            ctrl_d.alu_operation = dec_alu_op;
            ctrl_d.flag_write    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl_d.alu_operation = OP_ADD;
        ctrl_d.alu_src       = 1'b1;
        ctrl_d.dmem_req      = 1'b1;
        ctrl_d.mem_read      = (iclass == CLS_LOAD);
        ctrl_d.mem_write     = (iclass == CLS_STORE);
      end
      ST_WRITEBACK: begin
        ctrl_d.reg_write     = 1'b1;
        ctrl_d.reg_write_src = SRC_MEM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // PC load must coincide with the accepting edge, so these follow the inputs.
  assign bus.imem_req = ~reset & (state_q == ST_FETCH);
  assign bus.pc_write = ~reset & (((state_q == ST_FETCH) & bus.imem_ready) | branch_taken);
  assign bus.pc_src   = ~reset & branch_taken;

  assign bus.dmem_req      = ctrl_q.dmem_req;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.reg_write_src = ctrl_q.reg_write_src;
  assign bus.alu_operation = ctrl_q.alu_operation;
  assign bus.alu_src       = ctrl_q.alu_src;
  assign bus.flag_write    = ctrl_q.flag_write;
  assign bus.instr         = ir_q;
  assign bus.state         = STATE_WIDTH'(state_q);
  assign bus.branch_offset = PC_WIDTH'($signed(ir_q[OFFSET_WIDTH-1:0]));

`ifdef CU_PERF_CNT_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] retired_q, retired_d, cycle_q, cycle_d;

  // An instruction retires on the last cycle it occupies.
  always_comb begin
    retire    = (state_q == ST_EXECUTE) | (state_q == ST_WRITEBACK)
              | ((state_q == ST_MEM) & (iclass == CLS_STORE) & bus.dmem_ready);
    retired_d = retired_q + CNT_WIDTH'(retire);
    cycle_d   = cycle_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      retired_q <= retired_d;
      cycle_q   <= cycle_d;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; inputs change on the falling edge.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.INSTR_WIDTH(16), .PC_WIDTH(16)) bus ();

`ifdef CU_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] cycle_cnt;
`endif

  multicycle_control_unit #(
    .INSTR_WIDTH(16), .OPCODE_WIDTH(4), .OFFSET_WIDTH(12), .PC_WIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef CU_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
    , .cycle_cnt  (cycle_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in FETCH at a falling edge; returns settled in DECODE.
  task automatic fetch(input logic [15:0] ins);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = ins;
    #1;
    check("fetch_pc_write", 32'(bus.pc_write), 32'd1);
    check("fetch_pc_src", 32'(bus.pc_src), 32'd0);
    tick();
    bus.imem_ready = 1'b0;
    #1;
    check("decode_state", 32'(bus.state), 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  logic [3:0] br_ops [4];
  logic [3:0] br_exp [4];

  initial begin
    br_ops = '{OP_JMP, OP_BRZ, OP_BRNZ, OP_BRNS};
    br_exp = '{4'b1111, 4'b1100, 4'b0011, 4'b1010};  // bit index = {Z,S}

    reset          = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 16'h1234;
    bus.dmem_ready = 1'b1;
    bus.zero_flag  = 1'b0;
    bus.sign_flag  = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_pc_write", 32'(bus.pc_write), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check("rst_alu_op", 32'(bus.alu_operation), 32'd0);
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("idle_imem_req", 32'(bus.imem_req), 32'd1);
    check("idle_pc_write", 32'(bus.pc_write), 32'd0);

    // ADD, with a stray imem_ready during DECODE that must be ignored
    fetch(16'h0123);
    check("add_instr", 32'(bus.instr), 32'h0123);
    check("add_dec_reg_write", 32'(bus.reg_write), 32'd0);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 16'h5555;
    #1;
    check("add_dec_pc_write", 32'(bus.pc_write), 32'd0);
    tick();
    bus.imem_ready = 1'b0;
    #1;
    check("add_ex_state", 32'(bus.state), 32'd2);
    check("add_ex_instr", 32'(bus.instr), 32'h0123);
    check("add_ex_reg_write", 32'(bus.reg_write), 32'd1);
    check("add_ex_flag_write", 32'(bus.flag_write), 32'd1);
    check("add_ex_alu_op", 32'(bus.alu_operation), 32'h0);
    check("add_ex_alu_src", 32'(bus.alu_src), 32'd0);
    tick();
    #1;
    check("add_back_fetch", 32'(bus.state), 32'd0);
    check("add_fetch_reg_write", 32'(bus.reg_write), 32'd0);

    // SUB / LI / CMP decode in EXECUTE
    fetch(16'h2456); tick(); #1;
    check("sub_alu_op", 32'(bus.alu_operation), 32'h2);
    check("sub_reg_write", 32'(bus.reg_write), 32'd1);
    tick(); #1;
    fetch(16'h6012); tick(); #1;
    check("li_alu_op", 32'(bus.alu_operation), 32'h0);
    check("li_alu_src", 32'(bus.alu_src), 32'd1);
    check("li_reg_write", 32'(bus.reg_write), 32'd1);
    check("li_flag_write", 32'(bus.flag_write), 32'd0);
    tick(); #1;
    fetch(16'hF012); tick(); #1;
    check("cmp_alu_op", 32'(bus.alu_operation), 32'h2);
    check("cmp_flag_write", 32'(bus.flag_write), 32'd1);
    check("cmp_reg_write", 32'(bus.reg_write), 32'd0);
    tick(); #1;

    // L with dmem_ready arriving on the 4th MEM cycle
    fetch(16'h7ABC);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.dmem_ready = (i == 3);
      #1;
      check("ld_mem_state", 32'(bus.state), 32'd3);
      check("ld_dmem_req", 32'(bus.dmem_req), 32'd1);
      check("ld_mem_read", 32'(bus.mem_read), 32'd1);
      check("ld_mem_write", 32'(bus.mem_write), 32'd0);
      check("ld_alu_src", 32'(bus.alu_src), 32'd1);
    end
    tick();
    bus.dmem_ready = 1'b0;
    #1;
    check("ld_wb_state", 32'(bus.state), 32'd4);
    check("ld_wb_reg_write", 32'(bus.reg_write), 32'd1);
    check("ld_wb_src", 32'(bus.reg_write_src), 32'd1);
    check("ld_wb_dmem_req", 32'(bus.dmem_req), 32'd0);
    tick(); #1;
    check("ld_after_wb", 32'(bus.state), 32'd0);
    check("ld_after_reg_write", 32'(bus.reg_write), 32'd0);

    // ST with zero-wait memory returns straight to FETCH
    fetch(16'h8321);
    tick();
    bus.dmem_ready = 1'b1;
    #1;
    check("st_mem_write", 32'(bus.mem_write), 32'd1);
    check("st_mem_read", 32'(bus.mem_read), 32'd0);
    tick();
    bus.dmem_ready = 1'b0;
    #1;
    check("st_to_fetch", 32'(bus.state), 32'd0);
    check("st_dmem_req_off", 32'(bus.dmem_req), 32'd0);

    // BRZ with negative offset
    bus.zero_flag = 1'b1;
    fetch(16'hAFFE);
    check("brz_offset", 32'(bus.branch_offset), 32'hFFFE);
    tick(); #1;
    check("brz_z1_pc_write", 32'(bus.pc_write), 32'd1);
    check("brz_z1_pc_src", 32'(bus.pc_src), 32'd1);
    tick(); #1;
    bus.zero_flag = 1'b0;
    fetch(16'hAFFE);
    tick(); #1;
    check("brz_z0_pc_write", 32'(bus.pc_write), 32'd0);
    check("brz_z0_pc_src", 32'(bus.pc_src), 32'd0);
    tick(); #1;

    // Branch truth table over all Z/S combinations
    for (int k = 0; k < 4; k++) begin
      for (int zs = 0; zs < 4; zs++) begin
        logic [3:0] tbl;
        tbl = br_exp[k];
        bus.zero_flag = zs[1];
        bus.sign_flag = zs[0];
        fetch({br_ops[k], 12'h005});
        tick(); #1;
        check($sformatf("br%0h_zs%0d_pc_write", br_ops[k], zs), 32'(bus.pc_write), 32'(tbl[zs]));
        check($sformatf("br%0h_zs%0d_pc_src", br_ops[k], zs), 32'(bus.pc_src), 32'(tbl[zs]));
        tick(); #1;
      end
    end
    bus.zero_flag = 1'b0;
    bus.sign_flag = 1'b0;

    // Reset while a store waits in MEM
    fetch(16'h8123);
    tick(); #1;
    check("strst_dmem_req", 32'(bus.dmem_req), 32'd1);
    check("strst_mem_write", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("strst_dmem_req_drop", 32'(bus.dmem_req), 32'd0);
    check("strst_mem_write_drop", 32'(bus.mem_write), 32'd0);
    check("strst_state", 32'(bus.state), 32'd0);
    check("strst_instr", 32'(bus.instr), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("strst_fetch_req", 32'(bus.imem_req), 32'd1);

`ifdef CU_PERF_CNT_EN
    apply_reset();
    check("perf_rst_cycle", cycle_cnt, 32'd0);
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    bus.imem_rdata = 16'h0123;
    repeat (3) tick();
    bus.imem_rdata = 16'h8123;
    repeat (3) tick();
    bus.imem_rdata = 16'h7123;
    repeat (4) tick();
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    #1;
    check("perf_retired", retired_cnt, 32'd3);
    check("perf_cycles", cycle_cnt, 32'd10);
    check("perf_state", 32'(bus.state), 32'd0);
`else
    apply_reset();
    check("final_state", 32'(bus.state), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
